// File: rtl/xbar_ctx_sequencer.sv
// Crossbar context sequencer: steps through a small memory of encoded select/bypass
// words and drives the router's one-hot crossbar selects, regbypass and exec strobe.
//
// state | meaning
// IDLE  | context memory writable, waiting for start
// RUN   | presenting one context per unstalled cycle
module xbar_ctx_sequencer #(
    parameter int NUM_PORTS   = 7,
    parameter int NUM_CTX     = 16,
    parameter int LOG_NUM_CTX = $clog2(NUM_CTX),
    parameter int CFG_WIDTH   = 32
) (
    input  logic                                  clk_g_0,
    input  logic                                  reset,
    input  logic                                  i__cfg_wr_en,
    input  logic [LOG_NUM_CTX-1:0]                i__cfg_wr_addr,
    input  logic [CFG_WIDTH-1:0]                  i__cfg_wr_data,
    output logic                                  o__cfg_wr_ready,
    input  logic                                  i__start,
    input  logic [LOG_NUM_CTX-1:0]                i__ctx_last,
    input  logic [15:0]                           i__iter_count,
    input  logic                                  i__stall,
    input  logic                                  i__abort,
    output logic [NUM_PORTS-1:0][NUM_PORTS-1:0]   o__xbar_sel,
    output logic [3:0]                            o__regbypass,
    output logic                                  o__start_exec_shifted,
    output logic [LOG_NUM_CTX-1:0]                o__ctx_ptr,
    output logic                                  o__busy,
    output logic                                  o__done,
    output logic                                  o__cfg_err
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                              state_q, state_d;
    logic [CFG_WIDTH-1:0]                mem [NUM_CTX];
    logic [LOG_NUM_CTX-1:0]              rd_ptr;
    logic [LOG_NUM_CTX-1:0]              ctx_last;
    logic [15:0]                         iter_count;
    logic [15:0]                         iter_cnt;
    logic                                fin_q;
    logic [CFG_WIDTH-1:0]                word;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] sel_d;
    logic                                dec_err;
    logic                                wrap;
    logic                                do_start, do_step, do_clear, finish;

    assign o__cfg_wr_ready = (state_q == IDLE);
    assign o__busy         = (state_q == RUN);
    assign wrap            = (rd_ptr == ctx_last);

    always_ff @(posedge clk_g_0) begin
        if (i__cfg_wr_en && state_q == IDLE)
            mem[i__cfg_wr_addr] <= i__cfg_wr_data;
    end

    // Each 4-bit field is {en, idx}; idx 7 with en set is a programming error.
    always_comb begin
        word    = mem[rd_ptr];
        sel_d   = '0;
        dec_err = 1'b0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            if (word[4*j+3]) begin
                if (word[4*j +: 3] == 3'd7)
                    dec_err = 1'b1;
                else
                    sel_d[j] = NUM_PORTS'(1) << word[4*j +: 3];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        do_start = 1'b0;
        do_step  = 1'b0;
        do_clear = 1'b0;
        finish   = 1'b0;
        case (state_q)
            IDLE: begin
                if (i__start) begin
                    state_d  = RUN;
                    do_start = 1'b1;
                end
            end
            RUN: begin
                // The final context stays up for exactly one cycle, then outputs clear.
                if (i__abort || fin_q) begin
                    state_d  = IDLE;
                    do_clear = 1'b1;
                end else if (!i__stall) begin
                    do_step = 1'b1;
                    finish  = wrap && (iter_count != 16'd0) &&
                              (16'(iter_cnt + 16'd1) == iter_count);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_g_0) begin
        if (reset) begin
            state_q               <= IDLE;
            o__xbar_sel           <= '0;
            o__regbypass          <= '0;
            o__start_exec_shifted <= 1'b0;
            o__ctx_ptr            <= '0;
            o__done               <= 1'b0;
            o__cfg_err            <= 1'b0;
            fin_q                 <= 1'b0;
            rd_ptr                <= '0;
            ctx_last              <= '0;
            iter_count            <= '0;
            iter_cnt              <= '0;
        end else begin
            state_q <= state_d;
            o__done <= 1'b0;
            if (do_start) begin
                ctx_last   <= i__ctx_last;
                iter_count <= i__iter_count;
                rd_ptr     <= '0;
                iter_cnt   <= '0;
                o__cfg_err <= 1'b0;
                fin_q      <= 1'b0;
            end
            if (do_clear) begin
                o__xbar_sel           <= '0;
                o__regbypass          <= '0;
                o__start_exec_shifted <= 1'b0;
                o__ctx_ptr            <= '0;
                fin_q                 <= 1'b0;
            end
            if (do_step) begin
                o__xbar_sel           <= sel_d;
                o__regbypass          <= word[CFG_WIDTH-1 -: 4];
                o__start_exec_shifted <= 1'b1;
                o__ctx_ptr            <= rd_ptr;
                o__done               <= finish;
                fin_q                 <= finish;
                if (dec_err)
                    o__cfg_err <= 1'b1;
                if (wrap) begin
                    rd_ptr   <= '0;
                    iter_cnt <= iter_cnt + 16'd1;
                end else begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_xbar_ctx_sequencer.sv
// Directed bench for xbar_ctx_sequencer: programs contexts, runs sequences and
// compares each presented cycle against hand-computed select/bypass values.
module tb_xbar_ctx_sequencer;

    logic             clk_g_0 = 1'b0;
    logic             reset;
    logic             cfg_wr_en;
    logic [3:0]       cfg_wr_addr;
    logic [31:0]      cfg_wr_data;
    logic             cfg_wr_ready;
    logic             start;
    logic [3:0]       ctx_last;
    logic [15:0]      iter_count;
    logic             stall;
    logic             abort;
    logic [6:0][6:0]  xbar_sel;
    logic [3:0]       regbypass;
    logic             exec;
    logic [3:0]       ctx_ptr;
    logic             busy;
    logic             done;
    logic             cfg_err;

    int checks = 0;
    int errors = 0;

    always #5 clk_g_0 = ~clk_g_0;

    xbar_ctx_sequencer dut (
        .clk_g_0               (clk_g_0),
        .reset                 (reset),
        .i__cfg_wr_en          (cfg_wr_en),
        .i__cfg_wr_addr        (cfg_wr_addr),
        .i__cfg_wr_data        (cfg_wr_data),
        .o__cfg_wr_ready       (cfg_wr_ready),
        .i__start              (start),
        .i__ctx_last           (ctx_last),
        .i__iter_count         (iter_count),
        .i__stall              (stall),
        .i__abort              (abort),
        .o__xbar_sel           (xbar_sel),
        .o__regbypass          (regbypass),
        .o__start_exec_shifted (exec),
        .o__ctx_ptr            (ctx_ptr),
        .o__busy               (busy),
        .o__done               (done),
        .o__cfg_err            (cfg_err)
    );

    task automatic tick();
        @(posedge clk_g_0);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        cfg_wr_en   = 1'b1;
        cfg_wr_addr = a;
        cfg_wr_data = d;
        tick();
        cfg_wr_en   = 1'b0;
    endtask

    task automatic start_run(input logic [3:0] last, input logic [15:0] iters);
        start      = 1'b1;
        ctx_last   = last;
        iter_count = iters;
        tick();
        start = 1'b0;
    endtask

    // Full 49-bit select with a single row j set to r.
    function automatic logic [63:0] row(input int j, input logic [6:0] r);
        logic [6:0][6:0] s;
        s    = '0;
        s[j] = r;
        return 64'(s);
    endfunction

    initial begin
        bit bad;
        reset = 1'b1; cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_data = '0;
        start = 1'b0; ctx_last = '0; iter_count = '0; stall = 1'b0; abort = 1'b0;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_ready", cfg_wr_ready, 1);
        chk("rst_exec", exec, 0);
        chk("rst_sel", 64'(xbar_sel), 0);
        chk("rst_done_err", {done, cfg_err}, 0);
        reset = 1'b0;

        // Basic two-context, two-iteration program.
        wr(4'd0, 32'h0000_0009);
        wr(4'd1, 32'hA000_00C0);
        start_run(4'd1, 16'd2);
        chk("t1_busy", busy, 1);
        chk("t1_exec_lat", exec, 0);
        tick();
        chk("t1_c0_sel", 64'(xbar_sel), row(0, 7'b0000010));
        chk("t1_c0_misc", {exec, regbypass, ctx_ptr, done}, {1'b1, 4'h0, 4'd0, 1'b0});
        tick();
        chk("t1_c1_sel", 64'(xbar_sel), row(1, 7'b0010000));
        chk("t1_c1_misc", {exec, regbypass, ctx_ptr, done}, {1'b1, 4'hA, 4'd1, 1'b0});
        tick();
        chk("t1_c2_sel", 64'(xbar_sel), row(0, 7'b0000010));
        chk("t1_c2_done", done, 0);
        tick();
        chk("t1_c3_sel", 64'(xbar_sel), row(1, 7'b0010000));
        chk("t1_c3_done", done, 1);
        tick();
        chk("t1_end", {exec, done, busy, cfg_wr_ready}, 4'b0001);
        chk("t1_end_sel", {64'(xbar_sel), regbypass}, 0);

        // Stall three cycles while context 1 is presented.
        start_run(4'd1, 16'd2);
        tick();
        chk("t2_c0", ctx_ptr, 0);
        tick();
        chk("t2_c1", ctx_ptr, 1);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_hold", {exec, ctx_ptr, done, regbypass}, {1'b1, 4'd1, 1'b0, 4'hA});
        end
        stall = 1'b0;
        tick();
        chk("t2_c0b", ctx_ptr, 0);
        tick();
        chk("t2_c1b", {ctx_ptr, done}, {4'd1, 1'b1});
        tick();
        chk("t2_end", {exec, busy}, 0);

        // Endless run on a single context, then abort.
        start_run(4'd0, 16'd0);
        bad = 1'b0;
        for (int i = 0; i < 120; i++) begin
            tick();
            if (exec !== 1'b1 || done !== 1'b0 || ctx_ptr !== 4'd0 ||
                64'(xbar_sel) !== row(0, 7'b0000010))
                bad = 1'b1;
        end
        chk("t3_endless", bad, 0);
        chk("t3_busy", busy, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t3_abort", {exec, done, busy, cfg_wr_ready, ctx_ptr}, {4'b0001, 4'd0});
        chk("t3_abort_sel", 64'(xbar_sel), 0);
        tick();
        chk("t3_nodone", done, 0);

        // Invalid index on out2, valid out0 <- in3.
        wr(4'd0, 32'h0000_0F0B);
        start_run(4'd0, 16'd1);
        tick();
        chk("t4_sel", 64'(xbar_sel), row(0, 7'b0001000));
        chk("t4_err", {cfg_err, done}, 2'b11);
        tick(); tick();
        chk("t4_sticky", {cfg_err, busy}, 2'b10);
        wr(4'd0, 32'h0000_0009);
        start_run(4'd0, 16'd1);
        chk("t4_clear", cfg_err, 0);
        tick(); tick();

        // Writes and starts during RUN are ignored; also exercise row 6.
        wr(4'd2, 32'h3E00_0000);
        start_run(4'd2, 16'd1);
        chk("t5_ready", cfg_wr_ready, 0);
        cfg_wr_en = 1'b1; cfg_wr_addr = 4'd0; cfg_wr_data = 32'hFFFF_FFFF;
        start = 1'b1; ctx_last = 4'd0; iter_count = 16'd5;
        tick();
        chk("t5_c0", ctx_ptr, 0);
        tick();
        chk("t5_c1", ctx_ptr, 1);
        tick();
        chk("t5_c2_sel", 64'(xbar_sel), row(6, 7'b1000000));
        chk("t5_c2_misc", {regbypass, ctx_ptr, done}, {4'h3, 4'd2, 1'b1});
        cfg_wr_en = 1'b0; start = 1'b0;
        tick();
        chk("t5_idle", busy, 0);
        start_run(4'd0, 16'd1);
        tick();
        chk("t5_mem_kept", 64'(xbar_sel), row(0, 7'b0000010));
        chk("t5_err_clean", cfg_err, 0);
        tick();

        // Reset in the middle of the second iteration.
        start_run(4'd1, 16'd2);
        tick(); tick(); tick();
        chk("t6_pre", {ctx_ptr, busy}, {4'd0, 1'b1});
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_rst", {exec, done, busy, cfg_wr_ready, cfg_err, regbypass}, {5'b00010, 4'h0});
        chk("t6_rst_sel", 64'(xbar_sel), 0);
        start_run(4'd1, 16'd2);
        tick();
        chk("t6_restart", {ctx_ptr, exec}, {4'd0, 1'b1});
        chk("t6_restart_sel", 64'(xbar_sel), row(0, 7'b0000010));
        abort = 1'b1;
        tick();
        abort = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
